// File: rtl/div_issue_stage.sv
// Issue stage of the pipelined non-restoring divider: operand handshake, launch
// register, in-flight limiter and a tag FIFO returning dz/overflow flags with each result.
module div_issue_stage #(
  parameter int unsigned DIVIDEND_W   = 28,
  parameter int unsigned DIVISOR_W    = 20,
  parameter int unsigned Q_W          = 8,
  parameter int unsigned MAX_INFLIGHT = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  start,
  output logic [DIVIDEND_W-1:0] divided,
  output logic [DIVISOR_W-1:0]  divisor_inv,
  input  logic                  done,
  output logic                  err_valid,
  output logic                  div_by_zero,
  output logic                  q_overflow,
  output logic                  protocol_err
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_INFLIGHT - 1);

  logic [CNT_W-1:0] inflight;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       tag_mem [MAX_INFLIGHT];

  logic       accept;
  logic       fifo_empty;
  logic       pop;
  logic       tag_dz;
  logic       tag_ov;
  logic [1:0] head;

  // The FIFO holds exactly one tag per op in flight, so its occupancy is the counter.
  assign fifo_empty = (inflight == '0);
  assign in_ready   = (inflight < MAX_CNT);
  assign accept     = in_valid & in_ready;
  assign pop        = done & ~fifo_empty;

  assign tag_dz = (divisor == '0);
  assign tag_ov = ~tag_dz & (dividend[DIVIDEND_W-1:Q_W] >= divisor);

  assign head        = tag_mem[rd_ptr];
  assign err_valid   = pop;
  assign div_by_zero = pop & head[1];
  assign q_overflow  = pop & head[0];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      start        <= 1'b0;
      divided      <= '0;
      divisor_inv  <= '0;
      protocol_err <= 1'b0;
      inflight     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      start       <= accept;
      divided     <= accept ? dividend : '0;
      divisor_inv <= accept ? ~divisor : '0;

      // A stray done (nothing in flight) is ignored apart from the sticky flag.
      if (done && fifo_empty)
        protocol_err <= 1'b1;

      case ({accept, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (accept)
        wr_ptr <= ptr_next(wr_ptr);
      if (pop)
        rd_ptr <= ptr_next(rd_ptr);
    end
  end

  always_ff @(posedge clock) begin
    if (accept)
      tag_mem[wr_ptr] <= {tag_dz, tag_ov};
  end

endmodule

// File: tb/tb_div_issue_stage.sv
// Directed bench for div_issue_stage: per-op vector table plus multi-cycle
// sequences for ordering, the in-flight limit, stray done and mid-flight reset.
module tb_div_issue_stage;

  localparam int unsigned DW = 28;
  localparam int unsigned VW = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          start;
  logic [DW-1:0] divided;
  logic [VW-1:0] divisor_inv;
  logic          done;
  logic          err_valid;
  logic          div_by_zero;
  logic          q_overflow;
  logic          protocol_err;

  div_issue_stage #(
    .DIVIDEND_W   (28),
    .DIVISOR_W    (20),
    .Q_W          (8),
    .MAX_INFLIGHT (9)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dividend     (dividend),
    .divisor      (divisor),
    .start        (start),
    .divided      (divided),
    .divisor_inv  (divisor_inv),
    .done         (done),
    .err_valid    (err_valid),
    .div_by_zero  (div_by_zero),
    .q_overflow   (q_overflow),
    .protocol_err (protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [VW-1:0] exp_inv;
    logic          exp_dz;
    logic          exp_ov;
  } vec_t;

  vec_t vecs [7];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0] = '{28'h0000640, 20'd40,     20'hFFFD7, 1'b0, 1'b0};
    vecs[1] = '{28'h1234567, 20'd0,      20'hFFFFF, 1'b1, 1'b0};
    vecs[2] = '{28'h0010000, 20'd256,    20'hFFEFF, 1'b0, 1'b1};
    vecs[3] = '{28'h0010000, 20'd257,    20'hFFEFE, 1'b0, 1'b0};
    vecs[4] = '{28'hFFFFFFF, 20'hFFFFF,  20'h00000, 1'b0, 1'b1};
    vecs[5] = '{28'h0000000, 20'd1,      20'hFFFFE, 1'b0, 1'b0};
    vecs[6] = '{28'h00FFFFF, 20'h00010,  20'hFFFEF, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; done = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_divided", 32'(divided), 32'd0);
    chk("rst_divinv", 32'(divisor_inv), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_errv", 32'(err_valid), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      dividend = vecs[i].dvd; divisor = vecs[i].dvs; in_valid = 1'b1;
      #1 chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_start", i), 32'(start), 32'd1);
      chk($sformatf("v%0d_divided", i), 32'(divided), 32'(vecs[i].dvd));
      chk($sformatf("v%0d_divinv", i), 32'(divisor_inv), 32'(vecs[i].exp_inv));
      chk($sformatf("v%0d_noerr", i), 32'(err_valid), 32'd0);
      tick();
      chk($sformatf("v%0d_start0", i), 32'(start), 32'd0);
      chk($sformatf("v%0d_divided0", i), 32'(divided), 32'd0);
      done = 1'b1;
      #1;
      chk($sformatf("v%0d_errv", i), 32'(err_valid), 32'd1);
      chk($sformatf("v%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].exp_dz));
      chk($sformatf("v%0d_ov", i), 32'(q_overflow), 32'(vecs[i].exp_ov));
      tick();
      done = 1'b0;
      #1 chk($sformatf("v%0d_errv0", i), 32'(err_valid), 32'd0);
    end

    // Flags return in issue order.
    in_valid = 1'b1;
    dividend = 28'h0010000; divisor = 20'd256; tick();
    divisor = 20'd257; tick();
    divisor = 20'd0; tick();
    in_valid = 1'b0;
    tick();
    done = 1'b1;
    #1 chk("ord0_ov", 32'({q_overflow, div_by_zero}), 32'b10);
    tick();
    chk("ord1_ov", 32'({err_valid, q_overflow, div_by_zero}), 32'b100);
    tick();
    chk("ord2_dz", 32'({err_valid, q_overflow, div_by_zero}), 32'b101);
    tick();
    done = 1'b0;
    #1 chk("ord_drained", 32'(in_ready), 32'd1);

    // Fill to the limit, then done and in_valid together.
    in_valid = 1'b1; dividend = 28'h0000100;
    for (int i = 0; i < 9; i++) begin
      divisor = (i % 3 == 0) ? 20'd0 : 20'd5;
      #1 chk($sformatf("fill%0d_ready", i), 32'(in_ready), 32'd1);
      tick();
    end
    divisor = 20'd0;
    chk("full_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("full_noacc", 32'(start), 32'd0);
    done = 1'b1;
    #1 chk("full_done_errv", 32'(err_valid), 32'd1);
    chk("full_done_dz", 32'(div_by_zero), 32'd1);
    tick();
    done = 1'b0;
    chk("full_noacc2", 32'(start), 32'd0);
    chk("eight_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("refill_start", 32'(start), 32'd1);
    chk("refill_ready0", 32'(in_ready), 32'd0);
    done = 1'b1;
    for (int i = 1; i < 10; i++) begin
      #1;
      chk($sformatf("drain%0d_errv", i), 32'(err_valid), 32'd1);
      chk($sformatf("drain%0d_dz", i), 32'(div_by_zero), (i == 9 || i % 3 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    done = 1'b0;
    #1 chk("drained_ready", 32'(in_ready), 32'd1);
    chk("drained_perr", 32'(protocol_err), 32'd0);

    // Stray done with nothing in flight.
    done = 1'b1;
    #1 chk("stray_errv", 32'(err_valid), 32'd0);
    tick();
    done = 1'b0;
    chk("stray_perr", 32'(protocol_err), 32'd1);
    in_valid = 1'b1; divisor = 20'd0; tick();
    in_valid = 1'b0; tick(); tick();
    chk("perr_sticky", 32'(protocol_err), 32'd1);
    done = 1'b1;
    #1 chk("post_stray_errv", 32'(err_valid), 32'd1);
    chk("post_stray_dz", 32'(div_by_zero), 32'd1);
    tick();
    done = 1'b0;

    // Reset with five ops in flight and start high.
    in_valid = 1'b1; divisor = 20'd9;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    chk("pre_rst_start", 32'(start), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_start", 32'(start), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_perr", 32'(protocol_err), 32'd0);
    done = 1'b1;
    #1 chk("mid_rst_empty", 32'(err_valid), 32'd0);
    tick();
    done = 1'b0;
    chk("mid_rst_stray", 32'(protocol_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
